// File: rtl/rc5_cbc_ctrl_if.sv
// rtl/rc5_cbc_ctrl_if.sv - system-side and rc5_core-side signal bundle for rc5_cbc_ctrl
// RC5_CBC_ECB_EN adds the per-block i_ecb select.
interface rc5_cbc_ctrl_if;
  logic [127:0] i_key;
  logic         i_key_en;
  logic [63:0]  i_iv;
  logic         i_iv_en;
  logic         i_flag;
  logic [63:0]  i_din;
  logic         i_din_en;
`ifdef RC5_CBC_ECB_EN
  logic         i_ecb;
`endif
  logic         o_ready;
  logic [63:0]  o_dout;
  logic         o_dout_en;
  logic         o_key_ok;
  logic         o_core_flag;
  logic [127:0] o_core_key;
  logic         o_core_key_en;
  logic [63:0]  o_core_din;
  logic         o_core_din_en;
  logic [63:0]  i_core_dout;
  logic         i_core_dout_en;
  logic         i_core_key_ok;

  modport slave (
`ifdef RC5_CBC_ECB_EN
    input  i_ecb,
`endif
    input  i_key, i_key_en, i_iv, i_iv_en, i_flag, i_din, i_din_en,
    input  i_core_dout, i_core_dout_en, i_core_key_ok,
    output o_ready, o_dout, o_dout_en, o_key_ok,
    output o_core_flag, o_core_key, o_core_key_en, o_core_din, o_core_din_en
  );

  modport master (
`ifdef RC5_CBC_ECB_EN
    output i_ecb,
`endif
    output i_key, i_key_en, i_iv, i_iv_en, i_flag, i_din, i_din_en,
    output i_core_dout, i_core_dout_en, i_core_key_ok,
    input  o_ready, o_dout, o_dout_en, o_key_ok,
    input  o_core_flag, o_core_key, o_core_key_en, o_core_din, o_core_din_en
  );
endinterface

// File: rtl/rc5_cbc_ctrl.sv
// rtl/rc5_cbc_ctrl.sv - CBC chaining controller wrapped around rc5_core, one block in flight
// RC5_CBC_ECB_EN enables per-block ECB pass-through via i_ecb.
module rc5_cbc_ctrl (
  input  logic          i_clk,
  input  logic          i_rst_n,
  rc5_cbc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEY, READY, BUSY} state_t;

  state_t      state, state_nxt;
  logic [63:0] chain, hold;
  logic [63:0] chain_use, core_din_nxt, dout_nxt, chain_done;
  logic        key_load, accept, done, iv_load;
  logic        ecb_in, ecb_q;

`ifdef RC5_CBC_ECB_EN
  assign ecb_in = bus.i_ecb;
`else
  assign ecb_in = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    key_load  = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_key_en) begin
          key_load  = 1'b1;
          state_nxt = KEY;
        end
      end
      // The core's key_ok from a previous key is stale while the new key pulse is still out.
      KEY: begin
        if (bus.i_core_key_ok && !bus.o_core_key_en) state_nxt = READY;
      end
      READY: begin
        if (bus.i_key_en) begin
          key_load  = 1'b1;
          state_nxt = KEY;
        end else if (bus.i_din_en) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.i_core_dout_en) begin
          done      = 1'b1;
          state_nxt = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An IV loaded alongside the block start applies to that block.
  always_comb begin
    iv_load      = bus.i_iv_en && (state != BUSY);
    chain_use    = iv_load ? bus.i_iv : chain;
    core_din_nxt = (bus.i_flag && !ecb_in) ? (bus.i_din ^ chain_use) : bus.i_din;
    dout_nxt     = (bus.o_core_flag || ecb_q) ? bus.i_core_dout : (bus.i_core_dout ^ chain);
    chain_done   = bus.o_core_flag ? bus.i_core_dout : hold;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chain             <= '0;
      hold              <= '0;
      ecb_q             <= 1'b0;
      bus.o_core_key    <= '0;
      bus.o_core_key_en <= 1'b0;
      bus.o_core_din    <= '0;
      bus.o_core_din_en <= 1'b0;
      bus.o_core_flag   <= 1'b0;
      bus.o_dout        <= '0;
      bus.o_dout_en     <= 1'b0;
    end else begin
      bus.o_core_key_en <= key_load;
      bus.o_core_din_en <= accept;
      bus.o_dout_en     <= done;
      if (key_load) bus.o_core_key <= bus.i_key;
      if (iv_load)  chain          <= bus.i_iv;
      if (accept) begin
        bus.o_core_din  <= core_din_nxt;
        bus.o_core_flag <= bus.i_flag;
        hold            <= bus.i_din;
        ecb_q           <= ecb_in;
      end
      if (done) begin
        bus.o_dout <= dout_nxt;
        if (!ecb_q) chain <= chain_done;
      end
    end
  end

  assign bus.o_ready  = (state == READY);
  assign bus.o_key_ok = bus.i_core_key_ok && (state != KEY);

endmodule

// File: tb/tb_rc5_cbc_ctrl.sv
// tb/tb_rc5_cbc_ctrl.sv - randomized self-checking bench for rc5_cbc_ctrl with a toy core model
// Define RC5_CBC_ECB_EN for both RTL and bench to exercise ECB pass-through.
module tb_rc5_cbc_ctrl;

  localparam logic [127:0] SPEC_KEY  = 128'h915f4619be41b2516355a50110a9ce91;
  localparam logic [63:0]  SPEC_MASK = 64'hd665c8424e60063f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc5_cbc_ctrl_if bus ();
  rc5_cbc_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_cmp = 0, n_err = 0;
  int din_pulses = 0, key_pulses = 0, exp_din_pulses = 0, exp_key_pulses = 0;
  logic [127:0] m_key = '0;
  logic [63:0]  m_chain = '0;
  logic         m_ecb = 1'b0;
  logic [63:0]  exp_core_din = '0;
  logic         exp_core_flag = 1'b0;
  logic [63:0]  last_core_din = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Toy invertible core: the spec key maps the published vectors; other keys rotate and mask.
  function automatic logic [63:0] rotl(input logic [63:0] v, input int r);
    return (v << r) | (v >> (64 - r));
  endfunction

  function automatic logic [63:0] toy_enc(input logic [127:0] k, input logic [63:0] x);
    if (k == SPEC_KEY) return x ^ SPEC_MASK;
    return rotl(x ^ k[63:0], int'(k[5:0] | 6'd1)) ^ k[127:64];
  endfunction

  function automatic logic [63:0] toy_dec(input logic [127:0] k, input logic [63:0] y);
    if (k == SPEC_KEY) return y ^ SPEC_MASK;
    return rotl(y ^ k[127:64], 64 - int'(k[5:0] | 6'd1)) ^ k[63:0];
  endfunction

  // Core stand-in: random key-schedule and block latency, checks what the controller launches.
  initial begin : core_stub
    logic [127:0] skey;
    logic [63:0]  sdin;
    logic         sflag;
    int kcnt, dcnt;
    skey = '0; sdin = '0; sflag = 1'b0; kcnt = 0; dcnt = 0;
    bus.i_core_dout = '0; bus.i_core_dout_en = 1'b0; bus.i_core_key_ok = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_core_dout_en = 1'b0;
      if (!rst_n) begin
        kcnt = 0; dcnt = 0;
        bus.i_core_key_ok = 1'b0;
        bus.i_core_dout = '0;
      end else begin
        if (bus.o_core_key_en) begin
          key_pulses++;
          skey = bus.o_core_key;
          bus.i_core_key_ok = 1'b0;
          kcnt = $urandom_range(2, 6);
        end else if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) bus.i_core_key_ok = 1'b1;
        end
        if (bus.o_core_din_en) begin
          din_pulses++;
          chk("core_din", bus.o_core_din, exp_core_din);
          chk("core_flag", bus.o_core_flag, exp_core_flag);
          sdin = bus.o_core_din; sflag = bus.o_core_flag; last_core_din = sdin;
          dcnt = $urandom_range(1, 5);
        end else if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin
            bus.i_core_dout = sflag ? toy_enc(skey, sdin) : toy_dec(skey, sdin);
            bus.i_core_dout_en = 1'b1;
          end
        end
      end
    end
  end

  task automatic load_key(input logic [127:0] k, input logic with_din);
    @(negedge clk);
    bus.i_key = k; bus.i_key_en = 1'b1; bus.i_din_en = with_din;
    @(negedge clk);
    bus.i_key_en = 1'b0; bus.i_din_en = 1'b0;
    exp_key_pulses++;
    chk("core_key_en_hi", bus.o_core_key_en, 1'b1);
    chk("core_key", bus.o_core_key, k);
    chk("key_ok_gated", bus.o_key_ok, 1'b0);
    chk("ready_in_key", bus.o_ready, 1'b0);
    @(negedge clk);
    chk("core_key_en_lo", bus.o_core_key_en, 1'b0);
    for (int i = 0; i < 40 && !bus.o_ready; i++) @(negedge clk);
    chk("key_ready", bus.o_ready, 1'b1);
    chk("key_ok", bus.o_key_ok, 1'b1);
    m_key = k;
  endtask

  task automatic load_iv(input logic [63:0] iv);
    @(negedge clk);
    bus.i_iv = iv; bus.i_iv_en = 1'b1;
    @(negedge clk);
    bus.i_iv_en = 1'b0;
    m_chain = iv;
  endtask

  // Reference: textbook CBC over the toy cipher; assumes the controller is in READY.
  task automatic run_block(input logic flag, input logic [63:0] din, input logic iv_en,
                           input logic [63:0] iv, input logic noise, output logic [63:0] got);
    logic [63:0] chain_use, core_out, exp_out;
    logic seen;
    chain_use     = iv_en ? iv : m_chain;
    exp_core_din  = (flag && !m_ecb) ? (din ^ chain_use) : din;
    exp_core_flag = flag;
    core_out      = flag ? toy_enc(m_key, exp_core_din) : toy_dec(m_key, din);
    exp_out       = (flag || m_ecb) ? core_out : (core_out ^ chain_use);
    m_chain       = chain_use;
    if (!m_ecb) m_chain = flag ? core_out : din;
    @(negedge clk);
    bus.i_flag = flag; bus.i_din = din; bus.i_din_en = 1'b1;
    bus.i_iv = iv; bus.i_iv_en = iv_en;
`ifdef RC5_CBC_ECB_EN
    bus.i_ecb = m_ecb;
`endif
    @(negedge clk);
    bus.i_din_en = 1'b0; bus.i_iv_en = 1'b0;
    exp_din_pulses++;
    chk("busy_not_ready", bus.o_ready, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bus.i_din_en = 1'b0; bus.i_iv_en = 1'b0; bus.i_key_en = 1'b0;
      if (bus.o_dout_en) begin
        seen = 1'b1;
        break;
      end
      if (noise) begin
        bus.i_din = {$urandom, $urandom}; bus.i_din_en = 1'($urandom);
        bus.i_iv = {$urandom, $urandom};  bus.i_iv_en = 1'($urandom);
        bus.i_key_en = 1'($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
    end
    chk("dout_seen", seen, 1'b1);
    chk("dout", bus.o_dout, exp_out);
    chk("ready_after", bus.o_ready, 1'b1);
    got = bus.o_dout;
  endtask

  initial begin : main
    logic [63:0] got;
    bus.i_key = '0; bus.i_key_en = 1'b0; bus.i_iv = '0; bus.i_iv_en = 1'b0;
    bus.i_flag = 1'b0; bus.i_din = '0; bus.i_din_en = 1'b0;
`ifdef RC5_CBC_ECB_EN
    bus.i_ecb = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.o_ready, 1'b0);
    chk("rst_dout", bus.o_dout, 64'h0);
    chk("rst_dout_en", bus.o_dout_en, 1'b0);
    chk("rst_key_ok", bus.o_key_ok, 1'b0);
    chk("rst_core", {bus.o_core_flag, bus.o_core_key_en, bus.o_core_din_en, bus.o_core_din}, '0);
    chk("rst_core_key", bus.o_core_key, '0);
    @(posedge clk); #2 rst_n = 1'b1;

    load_key(SPEC_KEY, 1'b0);
    run_block(1'b1, 64'h21a5dbee154b8f6d, 1'b0, 64'h0, 1'b0, got);
    chk("enc_vec1", got, 64'hf7c013ac5b2b8952);
    run_block(1'b1, 64'hd665c8424e60063f, 1'b0, 64'h0, 1'b0, got);
    chk("enc_vec2_core_in", last_core_din, 64'h21a5dbee154b8f6d);
    chk("enc_vec2", got, 64'hf7c013ac5b2b8952);
    load_iv(64'h0);
    run_block(1'b0, 64'hf7c013ac5b2b8952, 1'b0, 64'h0, 1'b0, got);
    chk("dec_vec1", got, 64'h21a5dbee154b8f6d);
    run_block(1'b0, 64'hf7c013ac5b2b8952, 1'b0, 64'h0, 1'b0, got);
    chk("dec_vec2", got, 64'hd665c8424e60063f);
    load_iv(64'h0);
    run_block(1'b0, 64'hf7c013ac5b2b8952, 1'b0, 64'h0, 1'b1, got);
    chk("dec_noise1", got, 64'h21a5dbee154b8f6d);
    run_block(1'b0, 64'hf7c013ac5b2b8952, 1'b0, 64'h0, 1'b1, got);
    chk("dec_noise2", got, 64'hd665c8424e60063f);

    // Key load and block start together: the block is dropped.
    load_key(SPEC_KEY, 1'b1);
    chk("both_set_no_block", din_pulses, exp_din_pulses);

    // Reset mid-block.
    exp_core_din = 64'h21a5dbee154b8f6d ^ m_chain; exp_core_flag = 1'b1;
    @(negedge clk);
    bus.i_flag = 1'b1; bus.i_din = 64'h21a5dbee154b8f6d; bus.i_din_en = 1'b1;
    @(negedge clk);
    bus.i_din_en = 1'b0;
    exp_din_pulses++;
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_ready", bus.o_ready, 1'b0);
    chk("mid_rst_outs", {bus.o_dout_en, bus.o_key_ok, bus.o_dout}, '0);
    chk("mid_rst_core", {bus.o_core_flag, bus.o_core_key_en, bus.o_core_din_en, bus.o_core_din}, '0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", bus.o_ready, 1'b0);
    m_chain = '0;
    load_key(SPEC_KEY, 1'b0);
    run_block(1'b1, 64'h21a5dbee154b8f6d, 1'b0, 64'h0, 1'b0, got);
    chk("post_rst_enc", got, 64'hf7c013ac5b2b8952);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) load_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
      else if (r == 1) load_iv({$urandom, $urandom});
      run_block(1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) == 0,
                {$urandom, $urandom}, 1'($urandom), got);
    end

`ifdef RC5_CBC_ECB_EN
    load_key(SPEC_KEY, 1'b0);
    load_iv(64'hffffffffffffffff);
    m_ecb = 1'b1;
    run_block(1'b1, 64'h21a5dbee154b8f6d, 1'b0, 64'h0, 1'b0, got);
    chk("ecb_vec", got, 64'hf7c013ac5b2b8952);
    m_ecb = 1'b0;
    run_block(1'b1, 64'h0, 1'b0, 64'h0, 1'b0, got);
    chk("ecb_chain_kept", last_core_din, 64'hffffffffffffffff);
`endif

    repeat (3) @(negedge clk);
    chk("din_pulse_count", din_pulses, exp_din_pulses);
    chk("key_pulse_count", key_pulses, exp_key_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
